// File: rtl/demux_stream_1to32_pkg.sv
// Shared widths and FSM encoding for the 1-to-32 stream collector.
package demux_stream_1to32_pkg;

  localparam int DATA_W = 17;
  localparam int LANES  = 32;
  localparam int SEL_W  = 8;
  localparam int IDX_W  = $clog2(LANES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/demux_stream_1to32_lane_reg.sv
// One lane of the collector: a plain enabled register, so only the
// addressed lane toggles on a write.
module demux_lane_reg
  import demux_stream_1to32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end

endmodule

// File: rtl/demux_stream_1to32.sv
// Stream-to-frame collector: steers valid/ready words into 32 lane registers
// (auto-increment or explicit select) and holds the frame until acknowledged.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no frame in progress, waiting for start
// ST_FILL | accepting words into lanes
// ST_HOLD | frame complete, out_data stable until out_ack
module demux_stream_1to32
  import demux_stream_1to32_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sel_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        lane_vld,
  output logic                    frame_done,
  input  logic                    out_ack,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    err_sel
);

  state_t             state, state_nxt;
  logic               sel_mode_q;
  logic               accept, start_fire, sel_ok, wr_en, err_fire, last_auto;
  logic [IDX_W-1:0]   wr_idx;
  logic [LANES-1:0]   wr_onehot, vld_after;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_FILL;
      ST_FILL: if (wr_en && (sel_mode_q ? (&vld_after) : last_auto)) state_nxt = ST_HOLD;
      ST_HOLD: if (out_ack) state_nxt = start ? ST_FILL : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == ST_FILL);
    frame_done = (state == ST_HOLD);
  end

  // Write decode: an out-of-range explicit select is accepted but dropped.
  always_comb begin
    accept     = in_valid && in_ready;
    start_fire = start && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ack));
    sel_ok     = !sel_mode_q || (in_sel < SEL_W'(LANES));
    wr_en      = accept && sel_ok;
    err_fire   = accept && !sel_ok;
    last_auto  = (cur_sel == SEL_W'(LANES - 1));
    wr_idx     = sel_mode_q ? in_sel[IDX_W-1:0] : cur_sel[IDX_W-1:0];
    wr_onehot  = '0;
    if (wr_en) wr_onehot[wr_idx] = 1'b1;
    vld_after  = lane_vld | wr_onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_mode_q <= 1'b0;
      cur_sel    <= '0;
      lane_vld   <= '0;
      err_sel    <= 1'b0;
    end else begin
      err_sel <= err_fire;
      if (start_fire) begin
        sel_mode_q <= sel_mode;
        cur_sel    <= '0;
        lane_vld   <= '0;
      end else if (wr_en) begin
        lane_vld <= vld_after;
        if (!sel_mode_q) cur_sel <= last_auto ? '0 : cur_sel + SEL_W'(1);
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_lane_reg u_lane (
      .clk (clk),
      .rst (rst),
      .we  (wr_onehot[i]),
      .d   (in_data),
      .q   (out_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_demux_stream_1to32.sv
// Randomized scoreboard bench for demux_stream_1to32: a frame-level model
// predicts per-cycle status, completed frames and select errors.
module tb_demux_stream_1to32;
  import demux_stream_1to32_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst, start, sel_mode, in_valid, in_ready, out_ack;
  logic                    frame_done, err_sel;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel, cur_sel;
  logic [LANES*DATA_W-1:0] out_data;
  logic [LANES-1:0]        lane_vld;

  always #5 clk = ~clk;

  demux_stream_1to32 dut (
    .clk(clk), .rst(rst), .start(start), .sel_mode(sel_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_data(out_data), .lane_vld(lane_vld), .frame_done(frame_done),
    .out_ack(out_ack), .cur_sel(cur_sel), .err_sel(err_sel)
  );

  typedef struct {
    logic                    rdy, done, err, cur_chk;
    logic [LANES-1:0]        vld;
    logic [SEL_W-1:0]        cur;
    logic [LANES*DATA_W-1:0] data;
  } status_t;

  typedef struct {
    logic [LANES*DATA_W-1:0] data;
    logic [LANES-1:0]        vld;
  } frame_t;

  status_t stat_q[$];
  frame_t  frame_q[$];
  int      err_q[$];
  int      checks = 0, errors = 0;

  // model: phase 0 idle, 1 collecting, 2 frame complete
  int                m_phase = 0;
  int                m_cur = 0;
  logic              m_mode = 1'b0;
  logic              m_err = 1'b0;
  logic [LANES-1:0]  m_vld = '0;
  logic [DATA_W-1:0] m_lane[LANES];

  function automatic logic [LANES*DATA_W-1:0] flat();
    logic [LANES*DATA_W-1:0] f;
    for (int i = 0; i < LANES; i++) f[i*DATA_W +: DATA_W] = m_lane[i];
    return f;
  endfunction

  task automatic begin_frame();
    m_phase = 1;
    m_vld   = '0;
    m_cur   = 0;
    m_mode  = sel_mode;
  endtask

  // Predict the effect of the coming rising edge, then move to the next negedge.
  task automatic step();
    status_t s;
    frame_t  fr;
    m_err = 1'b0;
    if (rst) begin
      m_phase = 0; m_vld = '0; m_cur = 0; m_mode = 1'b0;
      for (int i = 0; i < LANES; i++) m_lane[i] = '0;
    end else if (m_phase == 0) begin
      if (start) begin_frame();
    end else if (m_phase == 1) begin
      if (in_valid) begin
        if (!m_mode) begin
          m_lane[m_cur] = in_data;
          m_vld[m_cur]  = 1'b1;
          if (m_cur == LANES - 1) begin m_cur = 0; m_phase = 2; end
          else m_cur++;
        end else if (int'(in_sel) < LANES) begin
          m_lane[int'(in_sel)] = in_data;
          m_vld[int'(in_sel)]  = 1'b1;
          if (m_vld == {LANES{1'b1}}) m_phase = 2;
        end else begin
          m_err = 1'b1;
          err_q.push_back(int'(in_sel));
        end
        if (m_phase == 2) begin
          fr.data = flat();
          fr.vld  = m_vld;
          frame_q.push_back(fr);
        end
      end
    end else begin
      if (out_ack) begin
        if (start) begin_frame();
        else m_phase = 0;
      end
    end
    s.rdy = (m_phase == 1);
    s.done = (m_phase == 2);
    s.err = m_err;
    s.vld = m_vld;
    s.cur = SEL_W'(m_cur);
    s.cur_chk = !m_mode;
    s.data = flat();
    stat_q.push_back(s);
    @(negedge clk);
  endtask

  task automatic drive(input int r, input int st, input int sm, input int v,
                       input int unsigned d, input int sl, input int ack);
    rst      = (r != 0);
    start    = (st != 0);
    sel_mode = (sm != 0);
    in_valid = (v != 0);
    in_data  = DATA_W'(d);
    in_sel   = SEL_W'(sl);
    out_ack  = (ack != 0);
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 1, $urandom, $urandom_range(0, 31), 0);
  endtask

  task automatic expect_phase(input int ph, input string name);
    checks++;
    if (m_phase != ph) begin
      errors++;
      $display("FAIL %s: model phase got %0d exp %0d (cycle budget exhausted)", name, m_phase, ph);
    end
  endtask

  // monitor
  initial begin
    status_t s;
    frame_t  fr;
    int      bad;
    logic    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        checks++;
        bad = -1;
        for (int i = LANES - 1; i >= 0; i--)
          if (out_data[i*DATA_W +: DATA_W] !== s.data[i*DATA_W +: DATA_W]) bad = i;
        if (in_ready !== s.rdy || frame_done !== s.done || err_sel !== s.err ||
            lane_vld !== s.vld || (s.cur_chk && cur_sel !== s.cur) || bad >= 0) begin
          errors++;
          $display("FAIL status @%0t: in_ready got %b exp %b, frame_done got %b exp %b, err_sel got %b exp %b, lane_vld got %h exp %h, cur_sel got %0d exp %0d, first bad lane %0d got %h exp %h",
                   $time, in_ready, s.rdy, frame_done, s.done, err_sel, s.err, lane_vld, s.vld,
                   cur_sel, s.cur, bad, (bad >= 0) ? out_data[bad*DATA_W +: DATA_W] : '0,
                   (bad >= 0) ? s.data[bad*DATA_W +: DATA_W] : '0);
        end
      end
      if (frame_done && !prev_done) begin
        checks++;
        if (frame_q.size() == 0) begin
          errors++;
          $display("FAIL frame @%0t: frame_done rose got 1 exp 0 (no frame predicted)", $time);
        end else begin
          fr = frame_q.pop_front();
          for (int i = 0; i < LANES; i++)
            if (out_data[i*DATA_W +: DATA_W] !== fr.data[i*DATA_W +: DATA_W]) begin
              errors++;
              $display("FAIL frame lane %0d @%0t: got %h exp %h", i, $time,
                       out_data[i*DATA_W +: DATA_W], fr.data[i*DATA_W +: DATA_W]);
              break;
            end
          if (lane_vld !== fr.vld) begin
            errors++;
            $display("FAIL frame lane_vld @%0t: got %h exp %h", $time, lane_vld, fr.vld);
          end
        end
      end
      if (err_sel) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL err_sel @%0t: got 1 exp 0 (no bad select pending)", $time);
        end else void'(err_q.pop_front());
      end
      prev_done = frame_done;
    end
  end

  // stimulus
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 17'h1ffff, 0, 0);

    // auto fill, one word per cycle
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < LANES; i++) drive(0, 0, 0, 1, 32'h1 + 3 * i, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // explicit mode with an out-of-range select
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 32'h1abcd, 5, 0);
    drive(0, 0, 1, 1, 32'h0ffff, 40, 0);
    drive(0, 0, 1, 1, 32'h00123, 5, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000 && m_phase == 1; n++)
      drive(0, ($urandom_range(0, 9) == 0), $urandom_range(0, 1), ($urandom_range(0, 9) < 7),
            $urandom, $urandom_range(0, 39), 0);
    expect_phase(2, "explicit_fill");
    idle(1);

    // back-to-back into an auto frame with 30% valid
    drive(0, 1, 0, 0, 0, 0, 1);
    for (int n = 0; n < 2000 && m_phase == 1; n++)
      drive(0, 0, 0, ($urandom_range(0, 99) < 30), $urandom, $urandom, 0);
    expect_phase(2, "gapped_fill");

    // back-to-back again, then reset mid-frame after 10 accepts
    drive(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, $urandom, 0, 0);
    drive(1, 0, 0, 1, $urandom, 0, 0);
    drive(0, 0, 0, 1, 32'h15555, 0, 0);
    idle(2);

    // random explicit frame, released with ack alone
    drive(0, 1, 1, 0, 0, 0, 0);
    for (int n = 0; n < 3000 && m_phase == 1; n++)
      drive(0, $urandom_range(0, 1), 0, $urandom_range(0, 1), $urandom, $urandom_range(0, 34), 0);
    expect_phase(2, "random_explicit");
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(3);

    checks++;
    if (frame_q.size() != 0 || err_q.size() != 0 || stat_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending frames %0d errs %0d status %0d exp all 0",
               frame_q.size(), err_q.size(), stat_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_stream_1to32.md
# demux_stream_1to32

Sequential 1-to-32 demultiplexer/collector for the low-power systolic array: the write-side counterpart of the 32-to-1 result mux. It accepts a valid/ready stream of 17-bit words and steers each word into one of 32 lane registers, either by auto-incrementing select or by an explicit per-word select. It then holds the completed frame until the consumer acknowledges. Only the addressed lane register is enabled on each write, which keeps the design clock-gating friendly and limits switching power.

## Interface
- DATA_W, 17, word width (matches mux lane width)
- LANES, 32, number of lane registers
- SEL_W, 8, select width (matches mux sel)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new frame; sampled in IDLE, or in HOLD together with out_ack
- sel_mode  in  1  0 = auto-increment, 1 = explicit in_sel; latched at start
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts a word (high only in FILL)
- in_data  in  DATA_W  word to store
- in_sel  in  SEL_W  destination lane in explicit mode
- out_data  out  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- lane_vld  out  LANES  bit i set when lane i has been written in the current frame
- frame_done  out  1  high throughout HOLD
- out_ack  in  1  consumer has taken the frame
- cur_sel  out  SEL_W  next auto-mode lane
- err_sel  out  1  one-cycle pulse when an explicit in_sel is ≥ LANES

## Operation
- Handshake: a word is accepted when in_valid && in_ready.
- FSM states: IDLE, FILL, HOLD.
- IDLE
  - in_ready=0, frame_done=0.
  - On start: go to FILL, clear lane_vld, set cur_sel=0, latch sel_mode.
- FILL, auto mode
  - Each accept writes lane cur_sel, sets lane_vld[cur_sel], and increments cur_sel.
  - An accept at cur_sel==LANES-1 goes to HOLD; cur_sel then wraps to 0.
- FILL, explicit mode
  - An accept with in_sel<LANES writes lane in_sel and sets its lane_vld bit.
  - Rewriting an already-valid lane overwrites it without error.
  - An accept that makes lane_vld all ones goes to HOLD.
  - An accept with in_sel≥LANES drops the word, pulses err_sel, and leaves the state and lane_vld unchanged. The word still counts as accepted: in_ready was high.
- start during FILL is ignored.
- HOLD
  - in_ready=0, frame_done=1; out_data is stable.
  - out_ack alone goes to IDLE.
  - out_ack && start goes directly to FILL with the IDLE-start actions applied (zero-bubble back-to-back frames).
- out_data is never cleared except by rst. Lanes keep old values until overwritten; lane_vld tells the consumer which lanes are fresh.
- Reset (rst, any state including mid-frame): state=IDLE, out_data=0, lane_vld=0, cur_sel=0, frame_done=0, err_sel=0, in_ready=0, latched sel_mode=0.

## Timing
- Write latency is 1 cycle: the lane value and lane_vld bit update on the edge that accepts the word.
- frame_done rises in the cycle after the final accept and falls in the cycle after out_ack.
- err_sel is high in the cycle after the offending accept, for exactly one cycle.
- Throughput is 1 word/cycle. A full auto frame takes 32 accept cycles plus at least 1 HOLD cycle.
- in_ready is a registered function of state only, so it has no combinational path from in_valid.

## Structure
- Shared package/include holds DATA_W, LANES, SEL_W and the state encoding (IDLE=0, FILL=1, HOLD=2, 2 bits).
- One sub-module, demux_lane_reg: a DATA_W-wide register with synchronous reset and write enable, instantiated LANES times via generate.
- The top level contains the FSM, the select counter, the one-hot decode of the write enable, and the lane_vld register.

## Test plan
- Auto fill: start with sel_mode=0, stream words 0x00001+3*i for i=0..31 at one per cycle.
  - Lane i must equal 0x00001+3*i.
  - lane_vld must be 0xFFFFFFFF.
  - frame_done must rise on the cycle after the 32nd accept.
  - Loop out_data into mux32to1, sweep sel 0..31, and compare.
- Explicit mode with error: send in_sel=5 (0x1ABCD), then in_sel=40 (0x0FFFF), then in_sel=5 (0x00123).
  - err_sel pulses once, only for the in_sel=40 word.
  - lane 5 = 0x00123 and lane_vld=0x00000020.
  - The FSM remains in FILL.
- Backpressure/gaps: assert in_valid randomly at 30%.
  - Only accepted words are written, in order.
  - in_ready stays high in FILL.
- Back-to-back: in HOLD, assert out_ack and start in the same cycle.
  - The next cycle is FILL with lane_vld=0, cur_sel=0, and old out_data retained.
- Reset mid-frame: assert rst after 10 accepts.
  - Next cycle: IDLE, out_data=0, lane_vld=0, in_ready=0, frame_done=0.
  - A word presented with in_valid is not accepted.
